conv_layer_sequencer: RTL
=========================

Name: conv_layer_sequencer

Overview:
- Sequences a bank of NUM_CONVS parallel convolution units that share one input frame.
- Buffers one frame of FRAME = INPUT_LAYER_HEIGHT*KERNEL_WIDTH words from upstream, then pulses start to all units.
- Broadcasts the buffered frame to all units in lockstep and waits for every unit to finish.
- Serialises all unit outputs to one downstream valid/yumi port, then releases the units with a common yumi.

Parameters:
- NUM_CONVS, 4, number of convolution units driven.
- INPUT_LAYER_HEIGHT, 4, input rows per frame.
- KERNEL_HEIGHT, 3, kernel rows; OUT_H = INPUT_LAYER_HEIGHT-KERNEL_HEIGHT+1 outputs per unit.
- KERNEL_WIDTH, 2, channels per row (2 = I/Q).
- WORD_SIZE, 16, data word width.

Ports:
- clk_i, in, 1, clock.
- reset_i, in, 1, reset: asynchronous, active-high.
- valid_i, in, 1, upstream word valid.
- ready_o, out, 1, sequencer can accept an upstream word.
- data_i, in, WORD_SIZE, upstream sample.
- conv_start_o, out, 1, one-cycle start pulse to all units.
- conv_valid_o, out, 1, broadcast word valid to all units.
- conv_ready_i, in, NUM_CONVS, per-unit input ready.
- conv_data_o, out, WORD_SIZE, broadcast word.
- conv_valid_i, in, NUM_CONVS, per-unit result valid.
- conv_data_i, in, NUM_CONVS*OUT_H*WORD_SIZE, packed results [unit][position][word].
- conv_yumi_o, out, 1, common result-consumed strobe to all units.
- valid_o, out, 1, downstream word valid.
- yumi_i, in, 1, downstream consumes the current word.
- data_o, out, WORD_SIZE, downstream word.
- last_o, out, 1, current word is the final word of the frame.

Behaviour:
- Async reset: state goes to eFILL and all counters clear.
- Outputs during reset: ready_o=1, every other output 0 (data buses 0). Frame buffer contents are not reset.
- Counters: wr_cnt and rd_cnt run 0..FRAME-1; pos_cnt runs 0..OUT_H-1; unit_cnt runs 0..NUM_CONVS-1.
- eFILL: ready_o=1.
  - Each valid_i&&ready_o writes buf[wr_cnt] and increments wr_cnt.
  - The handshake at wr_cnt==FRAME-1 clears wr_cnt and moves to eSTART.
- eSTART: conv_start_o=1 for exactly one cycle, then unconditionally to eSTREAM.
- eSTREAM: conv_data_o=buf[rd_cnt].
  - conv_valid_o = &conv_ready_i. The broadcast is gated so every unit accepts the same word in the same cycle; no unit ever sees a handshake the others miss.
  - rd_cnt increments on each conv_valid_o. When conv_valid_o fires at rd_cnt==FRAME-1, rd_cnt clears and the state moves to eWAIT.
  - A stall on any unit's ready holds rd_cnt and conv_data_o stable.
- eWAIT: all conv outputs 0. Moves to eDRAIN in the first cycle &conv_valid_i==1. Partial completion waits; there is no timeout.
- eDRAIN: valid_o=1; data_o = conv_data_i[unit_cnt][pos_cnt] (combinational mux). The units hold their results stable until yumi.
  - Order: unit 0 positions 0..OUT_H-1, then unit 1, and so on. Total NUM_CONVS*OUT_H words.
  - On yumi_i: pos_cnt increments; when it wraps at OUT_H-1 it clears and unit_cnt increments.
  - last_o=1 when unit_cnt==NUM_CONVS-1 && pos_cnt==OUT_H-1.
  - yumi_i && last_o: conv_yumi_o=1 combinationally in that same cycle, all counters clear, next state eFILL.
- yumi_i is legal only while valid_o=1; yumi_i outside eDRAIN is ignored.
- valid_i outside eFILL is ignored (ready_o=0); no word is lost or written.
- Latency: the first conv_valid_o comes 2 cycles after the final upstream handshake (eSTART in between). With units always ready, the stream phase takes exactly FRAME cycles.
- Reset asserted mid-frame in any state returns to eFILL immediately, and outputs take their reset values without waiting for a clock. The units are reset by the same reset_i.
- Widths: counters use $clog2(N+1) bits. No arithmetic is done on data; words pass through bit-exact.
- Parameter legality: KERNEL_HEIGHT <= INPUT_LAYER_HEIGHT and NUM_CONVS >= 1. Check both in an initial block.

Test Plan:
All scenarios use NUM_CONVS=2, H=4, KH=3, KW=2 (FRAME=8, OUT_H=2).
- Basic frame: upstream sends 1..8 back-to-back; model units always ready and return unit u, pos p = 16'h(u*16+p).
  - Expect conv_start_o for one cycle, then conv_data_o 1..8 in 8 consecutive cycles.
  - Downstream words are 0x00, 0x01, 0x10, 0x11, with last_o only on 0x11.
- Ready stall: deassert conv_ready_i[1] for 3 cycles on word 5.
  - conv_valid_o=0 and conv_data_o=5 held for those 3 cycles.
  - Each unit receives exactly 8 words, in order.
- Skewed completion: unit 0 valid at cycle t, unit 1 at t+6.
  - valid_o first rises the cycle after unit 1's valid, not before.
- Downstream backpressure: yumi_i toggled 1,0,0,1,1,0,1.
  - Word order is unchanged and data_o is stable while yumi_i=0.
  - conv_yumi_o is a single pulse coinciding with the yumi on 0x11.
- Reset mid-stream: assert reset_i asynchronously after word 3 of eSTREAM.
  - Outputs clear immediately and ready_o=1.
  - The next full frame 9..16 runs cleanly, with no stale words in the stream.
- Input gating: hold valid_i=1 during eSTREAM/eDRAIN with data 0xDEAD.
  - ready_o=0 throughout and the buffer is unchanged; a back-to-back second frame streams its own data.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
// Frame-buffering sequencer for a bank of convolution units: fill one frame,
// broadcast it in lockstep, wait for every unit, then serialise all results.
//
// state   | meaning
// eFILL   | accepting upstream words into the frame buffer
// eSTART  | one-cycle start pulse to all units
// eSTREAM | broadcasting buffered words, gated on every unit being ready
// eWAIT   | waiting until every unit reports its results
// eDRAIN  | serialising results downstream; the final yumi releases the units

module conv_layer_sequencer #(
  parameter int NUM_CONVS          = 4,
  parameter int INPUT_LAYER_HEIGHT = 4,
  parameter int KERNEL_HEIGHT      = 3,
  parameter int KERNEL_WIDTH       = 2,
  parameter int WORD_SIZE          = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic                 conv_start_o,
  output logic                 conv_valid_o,
  input  logic [NUM_CONVS-1:0] conv_ready_i,
  output logic [WORD_SIZE-1:0] conv_data_o,
  input  logic [NUM_CONVS-1:0] conv_valid_i,
  input  logic [NUM_CONVS*(INPUT_LAYER_HEIGHT-KERNEL_HEIGHT+1)*WORD_SIZE-1:0] conv_data_i,
  output logic                 conv_yumi_o,
  output logic                 valid_o,
  input  logic                 yumi_i,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 last_o
);

  localparam int FRAME = INPUT_LAYER_HEIGHT * KERNEL_WIDTH;
  localparam int OUT_H = INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1;

  localparam int FW = $clog2(FRAME + 1);
  localparam int PW = $clog2(OUT_H + 1);
  localparam int UW = $clog2(NUM_CONVS + 1);

  // Index widths for the storage arrays themselves (counters carry one spare bit).
  localparam int FAW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int PAW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int UAW = (NUM_CONVS > 1) ? $clog2(NUM_CONVS) : 1;

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME - 1);
  localparam logic [PW-1:0] POS_LAST   = PW'(OUT_H - 1);
  localparam logic [UW-1:0] UNIT_LAST  = UW'(NUM_CONVS - 1);

  if (KERNEL_HEIGHT > INPUT_LAYER_HEIGHT) begin : g_bad_kernel_height
    $error("conv_layer_sequencer: KERNEL_HEIGHT must not exceed INPUT_LAYER_HEIGHT");
  end
  if (NUM_CONVS < 1) begin : g_bad_num_convs
    $error("conv_layer_sequencer: NUM_CONVS must be at least 1");
  end

  typedef enum logic [2:0] {
    eFILL,
    eSTART,
    eSTREAM,
    eWAIT,
    eDRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] wr_cnt_q, wr_cnt_d;
  logic [FW-1:0] rd_cnt_q, rd_cnt_d;
  logic [PW-1:0] pos_cnt_q, pos_cnt_d;
  logic [UW-1:0] unit_cnt_q, unit_cnt_d;
  logic          wr_en;
  logic          bcast_go;
  logic          drain_last;

  logic [WORD_SIZE-1:0] frame_q  [FRAME];
  logic [WORD_SIZE-1:0] result_w [NUM_CONVS][OUT_H];

  for (genvar gu = 0; gu < NUM_CONVS; gu++) begin : g_unit
    for (genvar gp = 0; gp < OUT_H; gp++) begin : g_pos
      assign result_w[gu][gp] = conv_data_i[(gu*OUT_H + gp)*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= eFILL;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      pos_cnt_q  <= '0;
      unit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      pos_cnt_q  <= pos_cnt_d;
      unit_cnt_q <= unit_cnt_d;
    end
  end

  // Frame storage is deliberately not reset; wr_cnt restarting at 0 makes stale contents unreachable.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      frame_q[wr_cnt_q[FAW-1:0]] <= data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    pos_cnt_d    = pos_cnt_q;
    unit_cnt_d   = unit_cnt_q;
    wr_en        = 1'b0;
    bcast_go     = 1'b0;
    drain_last   = 1'b0;
    ready_o      = 1'b0;
    conv_start_o = 1'b0;
    conv_valid_o = 1'b0;
    conv_data_o  = '0;
    conv_yumi_o  = 1'b0;
    valid_o      = 1'b0;
    data_o       = '0;
    last_o       = 1'b0;

    case (state_q)
      eFILL: begin
        ready_o = 1'b1;
        if (valid_i) begin
          wr_en = 1'b1;
          if (wr_cnt_q == FRAME_LAST) begin
            wr_cnt_d = '0;
            state_d  = eSTART;
          end else begin
            wr_cnt_d = wr_cnt_q + FW'(1);
          end
        end
      end

      eSTART: begin
        conv_start_o = 1'b1;
        state_d      = eSTREAM;
      end

      eSTREAM: begin
        // Only broadcast when every unit can take the word, keeping all units in lockstep.
        bcast_go     = &conv_ready_i;
        conv_valid_o = bcast_go;
        conv_data_o  = frame_q[rd_cnt_q[FAW-1:0]];
        if (bcast_go) begin
          if (rd_cnt_q == FRAME_LAST) begin
            rd_cnt_d = '0;
            state_d  = eWAIT;
          end else begin
            rd_cnt_d = rd_cnt_q + FW'(1);
          end
        end
      end

      eWAIT: begin
        if (&conv_valid_i) begin
          state_d = eDRAIN;
        end
      end

      eDRAIN: begin
        drain_last = (unit_cnt_q == UNIT_LAST) && (pos_cnt_q == POS_LAST);
        valid_o    = 1'b1;
        last_o     = drain_last;
        data_o     = result_w[unit_cnt_q[UAW-1:0]][pos_cnt_q[PAW-1:0]];
        if (yumi_i) begin
          if (drain_last) begin
            conv_yumi_o = 1'b1;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            pos_cnt_d   = '0;
            unit_cnt_d  = '0;
            state_d     = eFILL;
          end else if (pos_cnt_q == POS_LAST) begin
            pos_cnt_d  = '0;
            unit_cnt_d = unit_cnt_q + UW'(1);
          end else begin
            pos_cnt_d = pos_cnt_q + PW'(1);
          end
        end
      end

      default: begin
        state_d = eFILL;
      end
    endcase
  end

endmodule
